// File: rtl/mux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_sched_pkg
//  Brief   : Shared constants and the state type for the round-robin mux
//            scheduler (mux_rr_sched) and its arbiter (mux_rr_pick).
//  Rev     : 1.0  initial release
// ============================================================================
package mux_sched_pkg;

    localparam int NUM_PORTS_DEF = 10;
    localparam int SEL_WIDTH_DEF = 4;

    // Select value presented while no port holds a grant.
    localparam logic [SEL_WIDTH_DEF-1:0] SEL_IDLE = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : mux_rr_pick
//  Brief   : Combinational round-robin search. Looks for the first request
//            starting at ptr+1 and wrapping at NUM_PORTS-1 back to 0, so the
//            port at ptr itself is considered last.
//  Rev     : 1.0  initial release
// ============================================================================
module mux_rr_pick
    import mux_sched_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] winner,
    output logic                 any
);

    localparam int SLOTS = 2 ** SEL_WIDTH;

    // Zero-extended so every select value indexes a defined bit.
    logic [SLOTS-1:0] req_ext;
    int               idx;

    assign req_ext = SLOTS'(req);

    // Walk the candidates farthest-first so the nearest requester above ptr
    // is the last one written and therefore wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (req_ext[SEL_WIDTH'(idx)]) begin
                winner = SEL_WIDTH'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module  : mux_rr_sched
//  Brief   : Burst-oriented round-robin scheduler driving a mux select.
//            A granted port keeps the grant for up to BURST_MAX beats or
//            until it drops its request; re-arbitration happens in the
//            burst-ending cycle so consecutive grants have no idle gap.
//  Config  : MUX_SCHED_PRIO0_EN - port 0 wins every arbitration point where
//            it requests (except straight after its own burst, so other
//            ports are not starved); port-0 grants leave ptr untouched.
//  Rev     : 1.0  initial release
// ============================================================================
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int SEL_WIDTH = SEL_WIDTH_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 beat,
    output logic                 out_valid,
    output logic [SEL_WIDTH-1:0] out_port
);

    localparam int                   SLOTS     = 2 ** SEL_WIDTH;
    localparam int                   CNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(BURST_MAX - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_NONE  = {SEL_WIDTH{SEL_IDLE[0]}};
    localparam logic [SEL_WIDTH-1:0] PTR_RESET = SEL_WIDTH'(NUM_PORTS - 1);

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [SEL_WIDTH-1:0] ptr;

    logic [SLOTS-1:0]     req_ext;
    logic                 req_sel;
    logic                 burst_end;
    logic [SEL_WIDTH-1:0] ptr_next;
    logic [SEL_WIDTH-1:0] arb_ptr;
    logic [NUM_PORTS-1:0] arb_req;
    logic [SEL_WIDTH-1:0] pick_win;
    logic                 pick_any;
    logic [SEL_WIDTH-1:0] win;
    logic                 win_any;

    assign req_ext   = SLOTS'(req);
    assign req_sel   = (state == BURST) & req_ext[sel];
    assign beat      = req_sel & ready;
    assign burst_end = (state == BURST) &
                       (~req_sel | (beat & (beat_cnt == CNT_LAST)));

    // Pointer the arbiter searches from: the finishing port while a burst
    // ends, otherwise the stored pointer.
    always_comb begin
        ptr_next = sel;
        arb_req  = req;
`ifdef MUX_SCHED_PRIO0_EN
        if (sel == '0) begin
            ptr_next = ptr;
        end
        if ((state == BURST) && (sel == '0)) begin
            arb_req[0] = 1'b0;
        end
`endif
        arb_ptr = (state == BURST) ? ptr_next : ptr;
    end

    mux_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req    (arb_req),
        .ptr    (arb_ptr),
        .winner (pick_win),
        .any    (pick_any)
    );

    // Final winner: round-robin result, optionally overridden by port 0.
    always_comb begin
        win     = pick_win;
        win_any = pick_any;
`ifdef MUX_SCHED_PRIO0_EN
        if (arb_req[0] || (!pick_any && req[0])) begin
            win     = '0;
            win_any = 1'b1;
        end
`endif
    end

    // Scheduler state machine with registered grant/select and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= SEL_NONE;
            beat_cnt  <= '0;
            ptr       <= PTR_RESET;
            out_valid <= 1'b0;
            out_port  <= '0;
        end else begin
            out_valid <= beat;
            out_port  <= sel;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state    <= BURST;
                        grant    <= NUM_PORTS'(1) << win;
                        sel      <= win;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        ptr      <= ptr_next;
                        beat_cnt <= '0;
                        if (win_any) begin
                            grant <= NUM_PORTS'(1) << win;
                            sel   <= win;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            sel   <= SEL_NONE;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    sel   <= SEL_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mux_rr_sched
//  Brief   : Self-checking bench for mux_rr_sched: vector table, directed
//            corner sequences and randomized traffic against a reference
//            model of the scheduling rules.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mux_rr_sched;

    localparam int N   = 10;
    localparam int SW  = 4;
    localparam int BM  = 4;
    localparam int SEL_ALL = 15;
`ifdef MUX_SCHED_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          ready;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          beat;
    logic          out_valid;
    logic [SW-1:0] out_port;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: granted port (-1 = none), beats taken, pointer.
    int m_g, m_cnt, m_ptr, m_ov, m_op;

    mux_rr_sched #(
        .NUM_PORTS (N),
        .SEL_WIDTH (SW),
        .BURST_MAX (BM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ready     (ready),
        .grant     (grant),
        .sel       (sel),
        .beat      (beat),
        .out_valid (out_valid),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Round-robin winner for request vector r, searching after port p.
    function automatic int arbitrate(input logic [N-1:0] r, input int p, input bit skip0);
        if (PRIO && !skip0 && r[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int q;
            q = (p + k) % N;
            if (r[q] && !(skip0 && q == 0)) return q;
        end
        if (skip0 && r[0]) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_cnt = 0; m_ptr = N - 1; m_ov = 0; m_op = 0;
    endtask

    task automatic check_outputs();
        chk("grant", int'(grant), (m_g < 0) ? 0 : (1 << m_g));
        chk("sel", int'(sel), (m_g < 0) ? SEL_ALL : m_g);
        chk("out_valid", int'(out_valid), m_ov);
        chk("out_port", int'(out_port), m_op);
    endtask

    // One clock: apply inputs, check beat, advance the model, check outputs.
    task automatic drive(input logic [N-1:0] r, input bit rd, output bit seen_beat);
        bit eb;
        int ov_n, op_n;
        req = r; ready = rd;
        #1;
        seen_beat = beat;
        eb = (m_g >= 0) && rd && r[m_g];
        chk("beat", int'(beat), int'(eb));
        ov_n = int'(eb);
        op_n = (m_g < 0) ? SEL_ALL : m_g;
        if (m_g < 0) begin
            m_g = arbitrate(r, m_ptr, 1'b0);
            m_cnt = 0;
        end else if (!r[m_g] || (eb && m_cnt == BM - 1)) begin
            bit skip;
            skip = PRIO && (m_g == 0);
            if (!skip) m_ptr = m_g;
            m_g = arbitrate(r, m_ptr, skip);
            m_cnt = 0;
        end else if (eb) begin
            m_cnt++;
        end
        m_ov = ov_n; m_op = op_n;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel", int'(sel), SEL_ALL);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_port", int'(out_port), 0);
        chk("rst_beat", int'(beat), 0);
        @(posedge clk);
        #1;
        chk("rst_out_valid_edge", int'(out_valid), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        bit           rdy;
        bit           beat;
        int           sel;
    } vec_t;

    function automatic vec_t mk(input bit rs, input logic [N-1:0] r, input bit rd,
                                input bit b, input int s);
        vec_t v;
        v.rst = rs; v.req = r; v.rdy = rd; v.beat = b; v.sel = s;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        bit  sb;
        int  cnt5;
        int  seq[6];
        logic [N-1:0] rr;
        bit  rd;

        // Single requester: 4-beat burst then regrant; then idle.
        tbl[0] = mk(1, '0, 0, 0, 0);
        tbl[1] = mk(0, 10'h001, 1, 0, 0);
        for (int i = 2; i <= 9; i++) tbl[i] = mk(0, 10'h001, 1, 1, 0);
        tbl[10] = mk(0, 10'h000, 1, 0, SEL_ALL);
        // Port 3 stalls 5 cycles mid-burst; beat count must not advance.
        tbl[11] = mk(1, '0, 0, 0, 0);
        tbl[12] = mk(0, 10'h018, 1, 0, 3);
        tbl[13] = mk(0, 10'h018, 1, 1, 3);
        for (int i = 14; i <= 18; i++) tbl[i] = mk(0, 10'h018, 0, 0, 3);
        tbl[19] = mk(0, 10'h018, 1, 1, 3);
        tbl[20] = mk(0, 10'h018, 1, 1, 3);
        tbl[21] = mk(0, 10'h018, 1, 1, 4);

        if (PRIO) seq = '{0, 6, 0, 7, 0, 6};
        else      seq = '{0, 6, 7, 0, 6, 7};

        req = '0; ready = 1'b0; rst_n = 1'b1;
        model_reset();
        #2;

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end else begin
                drive(tbl[i].req, tbl[i].rdy, sb);
                chk("tbl_beat", int'(sb), int'(tbl[i].beat));
                chk("tbl_sel", int'(sel), tbl[i].sel);
                chk("tbl_grant", int'(grant), (tbl[i].sel == SEL_ALL) ? 0 : (1 << tbl[i].sel));
            end
        end

        // All ports requesting: 0..9,0 with 4 beats each, no bubbles.
        do_reset();
        drive(10'h3FF, 1'b1, sb);
        for (int k = 0; k < 44; k++) begin
            chk("rr_sel", int'(sel), (k / 4) % 10);
            drive(10'h3FF, 1'b1, sb);
            chk("rr_beat", int'(sb), 1);
        end

        // Port 5 drops its request after 2 beats.
        do_reset();
        cnt5 = 0;
        drive(10'h0A0, 1'b1, sb);
        chk("drop_sel5", int'(sel), 5);
        for (int k = 0; k < 2; k++) begin
            drive(10'h0A0, 1'b1, sb);
            if (out_valid && out_port == 5) cnt5++;
        end
        drive(10'h080, 1'b1, sb);
        if (out_valid && out_port == 5) cnt5++;
        chk("drop_next_sel", int'(sel), 7);
        for (int k = 0; k < 3; k++) begin
            drive(10'h080, 1'b1, sb);
            if (out_valid && out_port == 5) cnt5++;
        end
        chk("drop_port5_beats", cnt5, 2);

        // Ports 0, 6, 7 requesting: grant order depends on port-0 priority.
        do_reset();
        drive(10'h0C1, 1'b1, sb);
        for (int j = 0; j < 6; j++) begin
            chk("prio_seq", int'(sel), seq[j]);
            for (int k = 0; k < 4; k++) drive(10'h0C1, 1'b1, sb);
        end

        // Reset in the middle of a port-7 burst.
        do_reset();
        for (int k = 0; k < 3; k++) drive(10'h080, 1'b1, sb);
        chk("mid_sel7", int'(sel), 7);
        req = 10'h081;
        do_reset();
        drive(10'h081, 1'b1, sb);
        chk("after_rst_sel", int'(sel), 0);

        // Randomized traffic against the model.
        do_reset();
        rr = 10'h0C5;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(149) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(3) == 0) rr = N'($urandom & $urandom);
                rd = ($urandom_range(3) != 0);
                drive(rr, rd, sb);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
